// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl
// Time-shared debouncer for N_INPUTS mechanical inputs. A single prescaler
// produces a sample tick. A round-robin scan FSM then visits one channel per
// clock. Each channel keeps only a small stability counter next to its
// debounced level.
//
// Optional feature macro: DEBOUNCE_SCAN_EVENT_EN
//   defined     : single-entry event holding register with a valid/ready
//                 handshake, plus the sticky evt_drop flag
//   not defined : event outputs are tied to 0 and event_ready is ignored
//
// rst_n asserts asynchronously. It is expected to be released synchronously
// to clk by the board-level reset logic.

module debounce_scan_ctrl #(
    parameter int N_INPUTS       = 4,
    parameter int TICK_DIV       = 5000,
    parameter int STABLE_SAMPLES = 4,
    parameter int INVERT_LOGIC   = 0,
    localparam int IDW           = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [N_INPUTS-1:0] raw_in,
    output logic [N_INPUTS-1:0] db_out,
    output logic [N_INPUTS-1:0] rise_pulse,
    output logic [N_INPUTS-1:0] fall_pulse,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [IDW-1:0]      event_id,
    output logic                event_dir,
    output logic                overrun,
    output logic                evt_drop
);

    // counter can hold 0..STABLE_SAMPLES-1 with one bit of headroom
    localparam int CNTW = $clog2(STABLE_SAMPLES) + 1;
    localparam int PSW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PSW-1:0]  TICK_LAST = PSW'(TICK_DIV - 1);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(STABLE_SAMPLES - 1);
    localparam logic [IDW-1:0]  IDX_LAST  = IDW'(N_INPUTS - 1);

    // Reject parameter sets that the scan schedule cannot honour
    if (N_INPUTS < 2 || N_INPUTS > 16) begin : g_bad_n_inputs
        $error("debounce_scan_ctrl: N_INPUTS must be 2..16");
    end
    if (TICK_DIV <= N_INPUTS + 1) begin : g_bad_tick_div
        $error("debounce_scan_ctrl: TICK_DIV must exceed N_INPUTS+1");
    end
    if (STABLE_SAMPLES < 1) begin : g_bad_stable
        $error("debounce_scan_ctrl: STABLE_SAMPLES must be >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    logic [N_INPUTS-1:0] sync_meta;
    logic [N_INPUTS-1:0] sync_out;
    logic [N_INPUTS-1:0] s;
    logic [PSW-1:0]      ps_cnt;
    logic                tick;
    state_t              state;
    state_t              state_nxt;
    logic [IDW-1:0]      idx;
    logic [IDW-1:0]      idx_nxt;
    logic                scan_active;
    logic [CNTW-1:0]     cnt [N_INPUTS];
    logic                cur_s;
    logic                cur_db;
    logic [CNTW-1:0]     cur_cnt;
    logic                accept;

    // Two-flop synchronizer per raw input bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw_in;
            sync_out  <= sync_meta;
        end
    end

    assign s = (INVERT_LOGIC != 0) ? ~sync_out : sync_out;

    // Sample-tick prescaler; clearing on !enable restarts a full period later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (!enable) begin
            ps_cnt <= '0;
        end else if (ps_cnt == TICK_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PSW'(1);
        end
    end

    assign tick = enable && (ps_cnt == TICK_LAST);

    // Scan FSM state and channel index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state: a tick starts a scan of channels 0..N_INPUTS-1, one per cycle
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        scan_active = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                scan_active = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // A tick that lands while a scan is still running is lost; remember it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (tick && (state == SCAN)) begin
            overrun <= 1'b1;
        end
    end

    // Selected channel on this scan cycle
    always_comb begin
        cur_s   = s[idx];
        cur_db  = db_out[idx];
        cur_cnt = cnt[idx];
        accept  = scan_active && (cur_s != cur_db) && (cur_cnt == CNT_LAST);
    end

    // Stability counter, debounced level and edge pulses of the scanned channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                cnt[i] <= '0;
            end
            db_out     <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            if (scan_active) begin
                if (cur_s == cur_db) begin
                    cnt[idx] <= '0;
                end else if (accept) begin
                    cnt[idx]    <= '0;
                    db_out[idx] <= cur_s;
                    if (cur_s) begin
                        rise_pulse[idx] <= 1'b1;
                    end else begin
                        fall_pulse[idx] <= 1'b1;
                    end
                end else begin
                    cnt[idx] <= cur_cnt + CNTW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_SCAN_EVENT_EN
    logic           ev_valid_q;
    logic [IDW-1:0] ev_id_q;
    logic           ev_dir_q;
    logic           ev_drop_q;

    // One-entry event register; a full, unaccepted register drops new events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_dir_q   <= 1'b0;
            ev_drop_q  <= 1'b0;
        end else if (accept) begin
            if (!ev_valid_q || event_ready) begin
                ev_valid_q <= 1'b1;
                ev_id_q    <= idx;
                ev_dir_q   <= cur_s;
            end else begin
                ev_drop_q <= 1'b1;
            end
        end else if (ev_valid_q && event_ready) begin
            ev_valid_q <= 1'b0;
        end
    end

    assign event_valid = ev_valid_q;
    assign event_id    = ev_id_q;
    assign event_dir   = ev_dir_q;
    assign evt_drop    = ev_drop_q;
`else
    logic unused_event_ready;

    assign unused_event_ready = event_ready;
    assign event_valid        = 1'b0;
    assign event_id           = '0;
    assign event_dir          = 1'b0;
    assign evt_drop           = 1'b0;
`endif

endmodule
